vga_rect_address_sequencer: RTL

- Sequential successor to the combinational VGA coordinate-to-address translator.
- On a start command, walks a rectangle of pixels in raster order (left-to-right, top-to-bottom).
- Emits one (x, y, mem_address) beat per pixel on a valid/ready stream.
- Sits between drawing engines (sprite blit, digit render, clear-screen) and the VGA adapter write port. Screen geometry is parametrised rather than fixed to 160x120/320x240.

---
 rtl/vga_rect_address_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vga_rect_address_sequencer.sv
// Walks a rectangle in raster order and streams (x, y, address) beats on valid/ready.
// Define VGA_RECT_CLIP_EN to clip the rectangle against the screen edges.
module vga_rect_address_sequencer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int XW       = 9,
  parameter int YW       = 8,
  parameter int AW       = 17
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] rect_w,
  input  logic [YW-1:0] rect_h,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  localparam logic [AW-1:0] ScreenWA = AW'(SCREEN_W);

  state_e        state_q;
  logic [XW-1:0] cmdX_q, cmdW_q;
  logic [YW-1:0] cmdY_q, cmdH_q;
  logic [XW:0]   xEnd_q;
  logic [YW:0]   yEnd_q;
  logic [AW-1:0] rowStep_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [AW-1:0] addr_q;
  logic          valid_q, last_q, busy_q, done_q;

  logic [XW:0]   xSum_d, xEnd_d;
  logic [YW:0]   ySum_d, yEnd_d;
  logic          empty_d, loadLast_d;
  logic [AW-1:0] base_d, rowStep_d;
  logic          rowEnd_d, advLast_d;
  logic [XW-1:0] xAdv_d;
  logic [YW-1:0] yAdv_d;
  logic [AW-1:0] addrAdv_d;

  // Bounds and base address for the LOAD cycle; the only multiply lives here.
  always_comb begin
    xSum_d = {1'b0, cmdX_q} + {1'b0, cmdW_q};
    ySum_d = {1'b0, cmdY_q} + {1'b0, cmdH_q};
`ifdef VGA_RECT_CLIP_EN
    xEnd_d  = (xSum_d > (XW+1)'(SCREEN_W)) ? (XW+1)'(SCREEN_W) : xSum_d;
    yEnd_d  = (ySum_d > (YW+1)'(SCREEN_H)) ? (YW+1)'(SCREEN_H) : ySum_d;
    empty_d = (cmdW_q == '0) || (cmdH_q == '0) ||
              ({1'b0, cmdX_q} >= (XW+1)'(SCREEN_W)) ||
              ({1'b0, cmdY_q} >= (YW+1)'(SCREEN_H));
`else
    xEnd_d  = xSum_d;
    yEnd_d  = ySum_d;
    empty_d = (cmdW_q == '0) || (cmdH_q == '0);
`endif
    base_d     = AW'(cmdY_q) * ScreenWA + AW'(cmdX_q);
    rowStep_d  = ScreenWA + AW'(1) - AW'(xEnd_d - {1'b0, cmdX_q});
    loadLast_d = (({1'b0, cmdX_q} + (XW+1)'(1)) == xEnd_d) &&
                 (({1'b0, cmdY_q} + (YW+1)'(1)) == yEnd_d);
  end

  // Next pixel in raster order, reached by incremental adds only.
  always_comb begin
    rowEnd_d = (({1'b0, x_q} + (XW+1)'(1)) == xEnd_q);
    if (rowEnd_d) begin
      xAdv_d    = cmdX_q;
      yAdv_d    = y_q + YW'(1);
      addrAdv_d = addr_q + rowStep_q;
    end else begin
      xAdv_d    = x_q + XW'(1);
      yAdv_d    = y_q;
      addrAdv_d = addr_q + AW'(1);
    end
    advLast_d = (({1'b0, xAdv_d} + (XW+1)'(1)) == xEnd_q) &&
                (({1'b0, yAdv_d} + (YW+1)'(1)) == yEnd_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cmdX_q    <= '0;
      cmdY_q    <= '0;
      cmdW_q    <= '0;
      cmdH_q    <= '0;
      xEnd_q    <= '0;
      yEnd_q    <= '0;
      rowStep_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cmdX_q  <= x0;
            cmdY_q  <= y0;
            cmdW_q  <= rect_w;
            cmdH_q  <= rect_h;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (empty_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            xEnd_q    <= xEnd_d;
            yEnd_q    <= yEnd_d;
            rowStep_q <= rowStep_d;
            x_q       <= cmdX_q;
            y_q       <= cmdY_q;
            addr_q    <= base_d;
            last_q    <= loadLast_d;
            valid_q   <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (valid_q && out_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              x_q    <= xAdv_d;
              y_q    <= yAdv_d;
              addr_q <= addrAdv_d;
              last_q <= advLast_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign done      = done_q;

endmodule
